kcpsm6_port_fifo: RTL and testbench
===================================

# kcpsm6_port_fifo

Port-mapped byte FIFO peripheral that sits directly downstream of the PicoBlaze core wrapper. It decodes the core's `port_id`/`out_port`/`write_strobe`/`k_write_strobe`/`read_strobe` bus into a TX FIFO and an RX FIFO, and drives `in_port` back to the core. It presents valid/ready byte streams to fabric logic and raises an interrupt pulse on the wrapper's `interrupt` input.

## Interface
- `BASE_PORT`, 8'h00, base port address; must be 4-aligned; decode on `port_id[7:2]`.
- `DEPTH`, 16, entries per FIFO; power of two, 2..256.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, asynchronous, active-low.
- `port_id`  in  8  core port address.
- `out_port`  in  8  core write data.
- `write_strobe`  in  1  OUTPUT strobe.
- `k_write_strobe`  in  1  OUTPUTK strobe; decoded on `port_id[3:0]` against `BASE_PORT[3:0]`.
- `read_strobe`  in  1  INPUT strobe.
- `in_port`  out  8  registered read data to the core.
- `interrupt`  out  1  one-cycle interrupt request pulse.
- `tx_data`  out  8  TX FIFO head.
- `tx_valid`  out  1  TX FIFO not empty.
- `tx_ready`  in  1  fabric accepts `tx_data` when `tx_valid && tx_ready`.
- `rx_data`  in  8  byte from fabric.
- `rx_valid`  in  1  fabric offers `rx_data`.
- `rx_ready`  out  1  RX FIFO not full.

## Operation
- Register map (offset from `BASE_PORT`):
  - +0 DATA: write pushes TX; read returns RX head and pops.
  - +1 STATUS (read): b0 rx_empty, b1 rx_full, b2 tx_empty, b3 tx_full, b4 rx_ovf, b5 tx_ovf, b6 rx_udf, b7 0.
  - +2 CTRL (write): b0 rx_irq_en, b1 txe_irq_en, b6 flush both FIFOs, b7 clear sticky flags. b6/b7 are self-clearing. Readback is {6'b0, txe_irq_en, rx_irq_en}.
  - +3 RXLVL (read): RX occupancy. Saturates at 255 when DEPTH=256.
- TX push while full: byte dropped, tx_ovf set (sticky).
- RX push by fabric happens only when `rx_ready`; rx_ovf is never set by fabric. It is set only by flush of a non-empty RX FIFO (lost data).
- DATA read while RX empty: returns 8'h00, no pop, rx_udf set (sticky).
- Simultaneous push and pop on the same FIFO in one cycle is legal at any fill level: count unchanged when neither full nor empty. When full, the fabric push is blocked by `rx_ready` and the TX CPU push is dropped. When empty, the pop yields nothing.
- Flush and a same-cycle push: flush wins, FIFO empty afterwards.
- Interrupt condition C = (rx_irq_en && !rx_empty) || (txe_irq_en && tx_empty). `interrupt` pulses for one cycle on a 0→1 transition of C, using the registered previous C. No pulse while C stays high.
- Reset: FIFOs empty, pointers 0, flags 0, CTRL 0, `in_port`=0, `interrupt`=0, `tx_valid`=0, `rx_ready`=1.

## Timing
- `in_port` is registered from a `port_id` decode each cycle, giving 1-cycle latency. This is valid because the core holds `port_id` for 2 cycles before sampling.
- RX pop occurs on the `read_strobe` cycle; the next DATA read sees the new head.
- TX push on `write_strobe` is visible on `tx_valid`/`tx_data` the following cycle.
- FIFO memories are registered-pointer, show-ahead (head combinational from storage).
- Status flags reflect the state after the previous clock edge.
- `interrupt` is asserted 1 cycle after the edge that makes C true.

## Structure
- Package `kcpsm6_port_pkg`: register offsets, STATUS/CTRL bit indices.
- Sub-module `kcpsm6_sync_fifo` (parameter DEPTH, width 8; push/pop/flush, full/empty/count), instantiated twice.
- Top level holds decode, CTRL/flag registers, `in_port` mux register, interrupt edge detector.

## Test plan
- Reset, then read STATUS → 8'h05. `interrupt`=0, `tx_valid`=0, `rx_ready`=1.
- OUTPUT 0xA5, 0x3C to DATA with `tx_ready`=1 → `tx_data` 0xA5 then 0x3C, then `tx_valid`=0.
- DEPTH+1 TX writes with `tx_ready`=0 → STATUS b3=1, b5=1. Drain yields exactly DEPTH bytes in order.
- Fabric pushes 0x11 with CTRL=0x01 → one `interrupt` pulse. DATA read → 0x11, RXLVL=0. A second empty read → 0x00 with rx_udf=1.
- Full RX with simultaneous fabric offer and CPU read → one byte popped, `rx_ready` rises next cycle, no byte lost.
- Assert `rst` mid-stream with both FIFOs partly full → all outputs return to reset values immediately (async).

Source files
------------

// File: rtl/kcpsm6_port_pkg.sv
// Shared register map and bit positions for the PicoBlaze port-mapped FIFO peripheral.
package kcpsm6_port_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RXLVL  = 2'd3
    } reg_off_e;

    localparam int ST_RX_EMPTY = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_FULL  = 3;
    localparam int ST_RX_OVF   = 4;
    localparam int ST_TX_OVF   = 5;
    localparam int ST_RX_UDF   = 6;

    localparam int CTRL_RX_IRQ_EN  = 0;
    localparam int CTRL_TXE_IRQ_EN = 1;
    localparam int CTRL_FLUSH      = 6;
    localparam int CTRL_CLR_FLAGS  = 7;

    typedef struct packed {
        logic rx_udf;
        logic tx_ovf;
        logic rx_ovf;
    } sticky_t;

    // A 256-deep FIFO can hold 256 bytes, which does not fit the 8-bit level register.
    function automatic logic [7:0] sat_level(input logic [8:0] cnt);
        return (cnt > 9'd255) ? 8'hFF : cnt[7:0];
    endfunction

endpackage

// File: rtl/kcpsm6_sync_fifo.sv
// Single-clock byte FIFO with show-ahead head, flush and occupancy count.
module kcpsm6_sync_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    // A push into a full FIFO is refused even when a pop happens in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/kcpsm6_port_fifo.sv
// PicoBlaze port-mapped TX/RX byte FIFO peripheral with status, control and interrupt.
module kcpsm6_port_fifo
    import kcpsm6_port_pkg::*;
#(
    parameter logic [7:0] BASE_PORT = 8'h00,
    parameter int         DEPTH     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       k_write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam int AW = $clog2(DEPTH);

    logic          sel_io, sel_k, wr_en;
    reg_off_e      off;
    logic          tx_push, tx_pop, rx_push, data_rd;
    logic          ctrl_wr, flush, clr_flags;
    logic [3:0]    ctrl_rsvd_unused;

    logic [7:0]    tx_head, rx_head;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [AW:0]   tx_count_unused, rx_count;

    sticky_t       sticky_q, sticky_d;
    logic          rx_irq_en_q, rx_irq_en_d;
    logic          txe_irq_en_q, txe_irq_en_d;
    logic [7:0]    in_port_q, in_port_d;
    logic [7:0]    status;
    logic          irq_cond, irq_cond_q, irq_q;

    // OUTPUTK carries only a 4-bit port, so it is decoded on the low nibble alone.
    assign sel_io    = (port_id[7:2] == BASE_PORT[7:2]);
    assign sel_k     = (port_id[3:2] == BASE_PORT[3:2]);
    assign off       = reg_off_e'(port_id[1:0]);
    assign wr_en     = (write_strobe && sel_io) || (k_write_strobe && sel_k);
    assign tx_push   = wr_en && (off == REG_DATA);
    assign ctrl_wr   = wr_en && (off == REG_CTRL);
    assign data_rd   = read_strobe && sel_io && (off == REG_DATA);
    assign flush     = ctrl_wr && out_port[CTRL_FLUSH];
    assign clr_flags = ctrl_wr && out_port[CTRL_CLR_FLAGS];
    assign ctrl_rsvd_unused = out_port[5:2];

    assign tx_pop  = !tx_empty && tx_ready;
    assign rx_push = rx_valid && !rx_full;

    kcpsm6_sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (out_port),
        .pop       (tx_pop),
        .flush     (flush),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count_unused)
    );

    kcpsm6_sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (data_rd),
        .flush     (flush),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    assign tx_data  = tx_head;
    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

    // A new event in the same cycle as a clear survives the clear.
    always_comb begin
        sticky_d     = sticky_q;
        rx_irq_en_d  = rx_irq_en_q;
        txe_irq_en_d = txe_irq_en_q;
        if (clr_flags) sticky_d = '0;
        if (tx_push && tx_full && !flush) sticky_d.tx_ovf = 1'b1;
        if (flush && !rx_empty)           sticky_d.rx_ovf = 1'b1;
        if (data_rd && rx_empty)          sticky_d.rx_udf = 1'b1;
        if (ctrl_wr) begin
            rx_irq_en_d  = out_port[CTRL_RX_IRQ_EN];
            txe_irq_en_d = out_port[CTRL_TXE_IRQ_EN];
        end
    end

    always_comb begin
        status              = '0;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_OVF]   = sticky_q.rx_ovf;
        status[ST_TX_OVF]   = sticky_q.tx_ovf;
        status[ST_RX_UDF]   = sticky_q.rx_udf;
    end

    // Unselected ports read as zero so several peripherals can share the input bus.
    always_comb begin
        in_port_d = '0;
        if (sel_io) begin
            case (off)
                REG_DATA:   in_port_d = rx_empty ? 8'h00 : rx_head;
                REG_STATUS: in_port_d = status;
                REG_CTRL:   in_port_d = {6'b0, txe_irq_en_q, rx_irq_en_q};
                REG_RXLVL:  in_port_d = sat_level(9'(rx_count));
                default:    in_port_d = '0;
            endcase
        end
    end

    assign irq_cond = (rx_irq_en_q && !rx_empty) || (txe_irq_en_q && tx_empty);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_q     <= '0;
            rx_irq_en_q  <= 1'b0;
            txe_irq_en_q <= 1'b0;
            in_port_q    <= '0;
            irq_cond_q   <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            sticky_q     <= sticky_d;
            rx_irq_en_q  <= rx_irq_en_d;
            txe_irq_en_q <= txe_irq_en_d;
            in_port_q    <= in_port_d;
            irq_cond_q   <= irq_cond;
            irq_q        <= irq_cond && !irq_cond_q;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = irq_q;

endmodule

// File: tb/tb_kcpsm6_port_fifo.sv
// Scoreboard bench for kcpsm6_port_fifo: stimulus queues expected bytes, monitors compare.
module tb_kcpsm6_port_fifo;

    localparam int         DEPTH  = 16;
    localparam logic [7:0] BASE   = 8'h24;
    localparam logic [7:0] P_DATA = 8'h24;
    localparam logic [7:0] P_STAT = 8'h25;
    localparam logic [7:0] P_CTRL = 8'h26;
    localparam logic [7:0] P_LVL  = 8'h27;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] port_id, out_port, in_port, tx_data, rx_data;
    logic       write_strobe, k_write_strobe, read_strobe;
    logic       interrupt, tx_valid, tx_ready, rx_valid, rx_ready;

    typedef struct {
        string      name;
        logic [7:0] val;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    logic [7:0] tx_q[$];
    int         n_tests   = 0;
    int         n_fail    = 0;
    int         irq_count = 0;
    int         irq_base;

    always #5 clk = ~clk;

    kcpsm6_port_fifo #(.BASE_PORT(BASE), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .port_id        (port_id),
        .out_port       (out_port),
        .write_strobe   (write_strobe),
        .k_write_strobe (k_write_strobe),
        .read_strobe    (read_strobe),
        .in_port        (in_port),
        .interrupt      (interrupt),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    // Monitors sample on the falling edge, away from the active edge.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (tx_valid && tx_ready) begin
                    if (tx_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got %02h, expected no byte", tx_data);
                    end else begin
                        check("tx_data", tx_data, tx_q.pop_front());
                    end
                end
                if (read_strobe) begin
                    if (rd_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rd_unexpected: got %02h, expected no read", in_port);
                    end else begin
                        e = rd_q.pop_front();
                        check(e.name, in_port, e.val);
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (interrupt === 1'b1) irq_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] p, input logic [7:0] d, input bit k = 1'b0);
        @(posedge clk); #1;
        port_id  = p;
        out_port = d;
        if (k) k_write_strobe = 1'b1;
        else   write_strobe   = 1'b1;
        @(posedge clk); #1;
        write_strobe   = 1'b0;
        k_write_strobe = 1'b0;
    endtask

    // Port held two cycles, strobe in the second, as the core does for INPUT.
    task automatic cpu_read(input logic [7:0] p, input logic [7:0] exp, input string name);
        rd_exp_t e;
        @(posedge clk); #1;
        port_id = p;
        @(posedge clk); #1;
        e.name = name;
        e.val  = exp;
        rd_q.push_back(e);
        read_strobe = 1'b1;
        @(posedge clk); #1;
        read_strobe = 1'b0;
    endtask

    task automatic fabric_push(input logic [7:0] d);
        @(posedge clk); #1;
        rx_data  = d;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        port_id = '0; out_port = '0; rx_data = '0;
        write_strobe = 0; k_write_strobe = 0; read_strobe = 0;
        tx_ready = 0; rx_valid = 0;
        #12;
        check("rst_tx_valid",  {7'b0, tx_valid},  8'h00);
        check("rst_rx_ready",  {7'b0, rx_ready},  8'h01);
        check("rst_interrupt", {7'b0, interrupt}, 8'h00);
        check("rst_in_port",   in_port,           8'h00);
        @(negedge clk);
        rst = 1'b1;

        cpu_read(P_STAT, 8'h05, "status_reset");

        // Wrong upper port bits must not push.
        cpu_write(8'h04, 8'h77);
        idle(1);
        check("decode_miss_tx_valid", {7'b0, tx_valid}, 8'h00);

        // Streaming TX, including an OUTPUTK push decoded on the low nibble.
        tx_ready = 1'b1;
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'h5A);
        cpu_write(P_DATA, 8'hA5);
        cpu_write(P_DATA, 8'h3C);
        cpu_write(8'h04, 8'h5A, 1'b1);
        idle(3);
        check("tx_idle_valid", {7'b0, tx_valid}, 8'h00);
        check("tx_q_empty_1", 8'(tx_q.size()), 8'h00);

        // Overflow: DEPTH+1 writes, last dropped.
        tx_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            cpu_write(P_DATA, 8'(8'h40 + i));
            if (i < DEPTH) tx_q.push_back(8'(8'h40 + i));
        end
        cpu_read(P_STAT, 8'h29, "status_tx_full_ovf");
        tx_ready = 1'b1;
        idle(DEPTH + 3);
        check("tx_drain_valid", {7'b0, tx_valid}, 8'h00);
        check("tx_q_empty_2", 8'(tx_q.size()), 8'h00);
        cpu_read(P_STAT, 8'h25, "status_tx_ovf_sticky");
        cpu_write(P_CTRL, 8'h80);
        cpu_read(P_STAT, 8'h05, "status_cleared");

        // RX interrupt, pop, underflow.
        cpu_write(P_CTRL, 8'h01);
        idle(2);
        irq_base = irq_count;
        fabric_push(8'h11);
        idle(3);
        check("irq_rx_pulse", 8'(irq_count - irq_base), 8'h01);
        cpu_read(P_CTRL, 8'h01, "ctrl_readback");
        cpu_read(P_LVL,  8'h01, "rxlvl_one");
        cpu_read(P_DATA, 8'h11, "rx_data_11");
        cpu_read(P_LVL,  8'h00, "rxlvl_zero");
        cpu_read(P_DATA, 8'h00, "rx_empty_read");
        cpu_read(P_STAT, 8'h45, "status_rx_udf");
        check("irq_single", 8'(irq_count - irq_base), 8'h01);
        cpu_write(P_CTRL, 8'h80);

        // Full RX with fabric offer held during a CPU pop.
        for (int i = 0; i < DEPTH; i++) fabric_push(8'(8'h80 + i));
        idle(1);
        check("rx_full_ready", {7'b0, rx_ready}, 8'h00);
        cpu_read(P_LVL, 8'(DEPTH), "rxlvl_full");
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        cpu_read(P_DATA, 8'h80, "rx_full_pop");
        check("rx_ready_rise", {7'b0, rx_ready}, 8'h01);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("rx_refull", {7'b0, rx_ready}, 8'h00);
        for (int i = 1; i < DEPTH; i++) cpu_read(P_DATA, 8'(8'h80 + i), "rx_drain");
        cpu_read(P_DATA, 8'hEE, "rx_last_ee");
        cpu_read(P_STAT, 8'h05, "status_after_rx");

        // Flush of a non-empty RX loses data and flags rx_ovf.
        fabric_push(8'h99);
        cpu_write(P_CTRL, 8'h40);
        cpu_read(P_STAT, 8'h15, "status_flush_ovf");
        cpu_read(P_LVL,  8'h00, "rxlvl_flushed");
        cpu_write(P_CTRL, 8'h80);

        // Asynchronous reset mid-stream.
        tx_ready = 1'b0;
        cpu_write(P_DATA, 8'h01);
        cpu_write(P_DATA, 8'h02);
        cpu_write(P_DATA, 8'h03);
        fabric_push(8'h21);
        fabric_push(8'h22);
        cpu_write(P_CTRL, 8'h01);
        @(posedge clk); #1;
        port_id = P_LVL;
        @(posedge clk); #1;
        check("lvl_before_reset",      in_port,           8'h02);
        check("tx_valid_before_reset", {7'b0, tx_valid},  8'h01);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("async_tx_valid",  {7'b0, tx_valid},  8'h00);
        check("async_rx_ready",  {7'b0, rx_ready},  8'h01);
        check("async_in_port",   in_port,           8'h00);
        check("async_interrupt", {7'b0, interrupt}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        cpu_read(P_STAT, 8'h05, "status_after_reset");
        cpu_read(P_CTRL, 8'h00, "ctrl_after_reset");
        cpu_read(P_DATA, 8'h00, "rx_empty_after_reset");

        idle(2);
        check("rd_q_drained", 8'(rd_q.size()), 8'h00);
        check("tx_q_drained", 8'(tx_q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
